tx_fsm: RTL
===========

TX_FSM -- requirements
Module: tx_fsm

Interface
REQ-001 Parameter DATA_BITS, default 8: number of data bits per frame, legal range 5..8.
REQ-002 Parameter STOP_BITS, default 1: number of stop bits, legal values 1 or 2.
REQ-003 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; only used when TX_PARITY_EN is defined.
REQ-004 fsm_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 fsm_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 tx_start  in  1  single-cycle request to send tx_data.
REQ-007 tx_data  in  DATA_BITS  byte to send; sampled only in the accept cycle.
REQ-008 bit_tick  in  1  one-cycle strobe, one per bit period, from the baud generator.
REQ-009 tx_out  out  1  serial line; idles high.
REQ-010 load  out  1  pulse in the accept cycle (data captured into the shift register).
REQ-011 shift  out  1  pulse on each bit_tick that advances to the next data bit.
REQ-012 busy  out  1  high from the cycle after accept until the frame ends.
REQ-013 tx_done  out  1  one-cycle pulse when the last stop bit completes.

Function
REQ-014 States SHALL be IDLE, START, DATA, PARITY and STOP; PARITY exists only with TX_PARITY_EN.
REQ-015 Accept: in IDLE with tx_start=1, load SHALL be 1 combinationally, tx_data SHALL be captured, and the next state SHALL be START.
REQ-016 tx_start SHALL be ignored outside IDLE, with no capture, no load and no effect on the frame in flight.
REQ-017 bit_tick SHALL be ignored in IDLE, including when it coincides with tx_start; the accept still happens.
REQ-018 START SHALL drive tx_out=0 and move to DATA on the next bit_tick.
REQ-019 DATA SHALL drive tx_out = the register LSB, sending LSB first.
REQ-020 In DATA, each bit_tick SHALL assert shift, shift the register right and increment the bit counter.
REQ-021 After DATA_BITS ticks in DATA, the next state SHALL be PARITY if enabled, otherwise STOP.
REQ-022 PARITY SHALL drive the XOR of the captured bits, inverted if PARITY_ODD=1, and move to STOP on bit_tick.
REQ-023 STOP SHALL drive tx_out=1 for STOP_BITS ticks and then return to IDLE.
REQ-024 tx_done SHALL pulse high in the first IDLE cycle after STOP completes.
REQ-025 busy SHALL be 1 exactly in START, DATA, PARITY and STOP.
REQ-026 Back-to-back: tx_start in the tx_done cycle SHALL be accepted, giving no extra idle bit time.
REQ-027 The bit counter SHALL be $clog2(DATA_BITS+1) bits wide, SHALL clear on accept and SHALL NOT wrap within a frame.
REQ-028 tx_out SHALL be registered, with no combinational path from any input to tx_out.

Reset
REQ-029 While fsm_rst_n=0: state=IDLE, tx_out=1, busy=0, tx_done=0, shift register=0, counter=0.
REQ-030 load and shift SHALL be 0 during reset.
REQ-031 Reset mid-frame SHALL abort the frame immediately; tx_out SHALL return high with no partial stop bit.
REQ-032 After reset release, the first tx_start SHALL be accepted normally.

Configuration
REQ-033 Macro TX_PARITY_EN defined: the PARITY state is compiled in and frame length is 1+DATA_BITS+1+STOP_BITS ticks.
REQ-034 TX_PARITY_EN undefined: no PARITY state or logic, frame length is 1+DATA_BITS+STOP_BITS ticks, and PARITY_ODD is ignored.

Structure
REQ-035 Shared package uart_pkg SHALL hold the state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4) and DATA_BITS/STOP_BITS defaults, for use by rx_fsm and tx_fsm.
REQ-036 One sub-module, tx_shift_reg, SHALL hold the data register, bit counter and parity bit, controlled by load and shift; the FSM stays in tx_fsm.

Verification
REQ-037 Reset, then tx_start with tx_data=8'h55 and bit_tick every 16 clocks -> tx_out sequence 0,1,0,1,0,1,0,1,0,1; exactly 8 shift pulses; one tx_done.
REQ-038 tx_data=8'hA3 with TX_PARITY_EN and PARITY_ODD=0 -> parity bit 0; with PARITY_ODD=1 -> parity bit 1.
REQ-039 Second tx_start with 8'hFF mid-frame -> ignored; line carries only the first byte; busy stays 1.
REQ-040 tx_start in the tx_done cycle with 8'h00 -> load=1 that cycle; next frame's start bit follows with no gap.
REQ-041 fsm_rst_n low during DATA bit 3 -> tx_out=1 and busy=0 at once; new frame after release completes correctly.
REQ-042 STOP_BITS=2 -> stop high lasts 2 ticks; tx_done follows the second tick.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame defaults and a parity helper.
// Imported by both the transmit and receive controllers.
package uart_pkg;

    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Even parity over a zero-extended data word, inverted when odd is requested.
    function automatic logic calc_parity(input logic [7:0] i_bits, input logic i_odd);
        return (^i_bits) ^ i_odd;
    endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Transmit data path: shift register, data-bit counter and captured parity bit.
// The parity register exists only when TX_PARITY_EN is defined.
module tx_shift_reg
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    input  logic                 i_shift,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_lsb_next,
    output logic                 o_last_bit
`ifdef TX_PARITY_EN
    ,
    output logic                 o_parity
`endif
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    logic [DATA_BITS-1:0] r_data;
    logic [CNT_W-1:0]     r_cnt;

    // Capture on load; on shift move right and count, holding at DATA_BITS.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_data <= {1'b0, r_data[DATA_BITS-1:1]};
            if (r_cnt != CNT_W'(DATA_BITS)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end else begin
            r_data <= r_data;
            r_cnt  <= r_cnt;
        end
    end

    // Bit the line will carry once this edge's shift (if any) has happened.
    assign o_lsb_next = i_shift ? r_data[1] : r_data[0];
    assign o_last_bit = (r_cnt == CNT_W'(DATA_BITS - 1));

`ifdef TX_PARITY_EN
    logic r_parity;

    // Raw even parity of the captured word; odd inversion is applied by the FSM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parity <= 1'b0;
        end else if (i_load) begin
            r_parity <= calc_parity(8'(i_data), 1'b0);
        end else begin
            r_parity <= r_parity;
        end
    end

    assign o_parity = r_parity;
`endif

endmodule

// File: rtl/tx_fsm.sv
// UART transmit controller: frame sequencing, registered serial line and status strobes.
// Define TX_PARITY_EN to insert a parity bit between the data and stop bits.
module tx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int STOP_BITS  = DEF_STOP_BITS,
    parameter int PARITY_ODD = 0
) (
    input  logic                 fsm_clk,
    input  logic                 fsm_rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 bit_tick,
    output logic                 tx_out,
    output logic                 load,
    output logic                 shift,
    output logic                 busy,
    output logic                 tx_done
);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("tx_fsm: DATA_BITS must be in 5..8");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("tx_fsm: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("tx_fsm: PARITY_ODD must be 0 or 1");
    end

    uart_state_e r_state;
    uart_state_e w_state_next;
    logic        r_stop_cnt;
    logic        w_stop_cnt_next;
    logic        r_tx_out;
    logic        w_tx_out_next;
    logic        r_busy;
    logic        r_tx_done;
    logic        w_done_next;
    logic        w_load;
    logic        w_shift;
    logic        w_lsb_next;
    logic        w_last_bit;
`ifdef TX_PARITY_EN
    logic        w_parity_raw;
    logic        w_parity_bit;
`endif

    tx_shift_reg #(
        .DATA_BITS (DATA_BITS)
    ) u_shift_reg (
        .i_clk      (fsm_clk),
        .i_rst_n    (fsm_rst_n),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_data     (tx_data),
        .o_lsb_next (w_lsb_next),
        .o_last_bit (w_last_bit)
`ifdef TX_PARITY_EN
        ,
        .o_parity   (w_parity_raw)
`endif
    );

`ifdef TX_PARITY_EN
    assign w_parity_bit = w_parity_raw ^ 1'(PARITY_ODD);
`endif

    // Next state, strobes, and the value tx_out takes after this edge.
    always_comb begin
        w_state_next    = r_state;
        w_stop_cnt_next = r_stop_cnt;
        w_load          = 1'b0;
        w_shift         = 1'b0;
        w_done_next     = 1'b0;
        w_tx_out_next   = 1'b1;
        case (r_state)
            IDLE: begin
                // bit_tick is deliberately not looked at here
                if (tx_start && fsm_rst_n) begin
                    w_load       = 1'b1;
                    w_state_next = START;
                end else begin
                    w_state_next = IDLE;
                end
            end
            START: begin
                if (bit_tick) begin
                    w_state_next = DATA;
                end else begin
                    w_state_next = START;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    w_shift = 1'b1;
                    if (w_last_bit) begin
`ifdef TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_state_next = DATA;
                    end
                end else begin
                    w_state_next = DATA;
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    w_state_next = STOP;
                end else begin
                    w_state_next = PARITY;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                        w_state_next    = IDLE;
                        w_stop_cnt_next = 1'b0;
                        w_done_next     = 1'b1;
                    end else begin
                        w_state_next    = STOP;
                        w_stop_cnt_next = r_stop_cnt + 1'b1;
                    end
                end else begin
                    w_state_next = STOP;
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_stop_cnt_next = 1'b0;
            end
        endcase

        case (w_state_next)
            IDLE:    w_tx_out_next = 1'b1;
            START:   w_tx_out_next = 1'b0;
            DATA:    w_tx_out_next = w_lsb_next;
`ifdef TX_PARITY_EN
            PARITY:  w_tx_out_next = w_parity_bit;
`endif
            STOP:    w_tx_out_next = 1'b1;
            default: w_tx_out_next = 1'b1;
        endcase
    end

    // State and registered outputs; reset forces the line high at once.
    always_ff @(posedge fsm_clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            r_state    <= IDLE;
            r_stop_cnt <= 1'b0;
            r_tx_out   <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_tx_out   <= w_tx_out_next;
            r_busy     <= (w_state_next != IDLE);
            r_tx_done  <= w_done_next;
        end
    end

    assign tx_out  = r_tx_out;
    assign busy    = r_busy;
    assign tx_done = r_tx_done;
    assign load    = w_load;
    assign shift   = w_shift;

endmodule
